button_debounce_pulse: RTL and testbench

Conditions one raw mechanical push-button input into a clean debounced level and single-cycle press/release pulses, all in the 100 MHz domain. Sits directly upstream of the button-press counter and other button consumers. Those consumers can then run on the system clock and count exactly one event per physical press, instead of sampling a bouncing level on a slow derived clock. One instance per button.

---
 rtl/button_debounce_pulse.sv | 225 ++++++++++++++++++++++
 tb/tb_button_debounce_pulse.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_pulse.sv
// button_debounce_pulse
// Conditions one raw, bouncing push-button input into a debounced level plus
// single-cycle press and release pulses, all on CLK100MHZ.
//
// Optional feature: define BTN_REPEAT_EN to compile in auto-repeat. While the
// button is held, press_pulse then fires again after REPEAT_DELAY_CYCLES and
// every REPEAT_PERIOD_CYCLES after that. Without the macro there is exactly
// one press_pulse per accepted press, and no repeat counter exists.
//
// CPU_RESETN is asserted asynchronously. Its deassertion is taken as already
// synchronous to CLK100MHZ, because the top level synchronizes it.
module button_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES      = 1_000_000,
    parameter int CTR_W                = 20,
    parameter int REPEAT_DELAY_CYCLES  = 50_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 10_000_000,
    parameter int RPT_W                = 26
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    // Reject parameter sets that the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2 ||
        longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CTR_W) - 1)) begin : g_bad_debounce
        $error("button_debounce_pulse: DEBOUNCE_CYCLES out of range for CTR_W");
    end
    if (REPEAT_PERIOD_CYCLES < 1 || REPEAT_PERIOD_CYCLES > REPEAT_DELAY_CYCLES ||
        longint'(REPEAT_DELAY_CYCLES) > ((longint'(1) << RPT_W) - 1)) begin : g_bad_repeat
        $error("button_debounce_pulse: repeat timing out of range for RPT_W");
    end

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        HELD        = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             s2;
    state_t           state_reg;
    state_t           state_next;
    logic [CTR_W-1:0] ctr_reg;
    logic [CTR_W-1:0] ctr_next;
    logic             ctr_at_last;
    logic             level_reg;
    logic             level_next;
    logic             press_reg;
    logic             press_next;
    logic             release_reg;
    logic             release_next;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn_raw};
        end
    end

    assign s2          = sync_reg[1];
    assign ctr_at_last = (ctr_reg == CTR_LAST);

    // State register together with the debounce counter and the registered outputs.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_reg   <= IDLE;
            ctr_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ctr_reg     <= ctr_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    // Next-state logic: a change is accepted only after the synchronized input
    // has held the new value for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        state_next = state_reg;
        ctr_next   = ctr_reg;
        case (state_reg)
            IDLE: begin
                if (s2) begin
                    state_next = ARM_PRESS;
                    ctr_next   = '0;
                end
            end
            ARM_PRESS: begin
                if (!s2) begin
                    state_next = IDLE;
                    ctr_next   = '0;
                end else if (ctr_at_last) begin
                    state_next = HELD;
                    ctr_next   = '0;
                end else begin
                    ctr_next = ctr_reg + CTR_W'(1);
                end
            end
            HELD: begin
                if (!s2) begin
                    state_next = ARM_RELEASE;
                    ctr_next   = '0;
                end
            end
            ARM_RELEASE: begin
                if (s2) begin
                    state_next = HELD;
                    ctr_next   = '0;
                end else if (ctr_at_last) begin
                    state_next = IDLE;
                    ctr_next   = '0;
                end else begin
                    ctr_next = ctr_reg + CTR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                ctr_next   = '0;
            end
        endcase
    end

`ifdef BTN_REPEAT_EN
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY_CYCLES - REPEAT_PERIOD_CYCLES);

    logic [RPT_W-1:0] rpt_reg;
    logic [RPT_W-1:0] rpt_next;
    logic             rpt_fire;

    // Repeat counter register.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            rpt_reg <= '0;
        end else begin
            rpt_reg <= rpt_next;
        end
    end

    // Repeat timing: counts only while HELD persists, freezes during a release
    // qualification so a bounce back to HELD resumes where it left off, and
    // clears whenever the button is (or becomes) idle. Reloading to
    // DELAY-PERIOD makes later repeats arrive one PERIOD apart.
    always_comb begin
        rpt_next = rpt_reg;
        rpt_fire = 1'b0;
        case (state_reg)
            IDLE: begin
                rpt_next = '0;
            end
            ARM_PRESS: begin
                if (s2 && ctr_at_last) begin
                    rpt_next = '0;
                end
            end
            HELD: begin
                if (s2) begin
                    if (rpt_reg == RPT_LAST) begin
                        rpt_fire = 1'b1;
                        rpt_next = RPT_RELOAD;
                    end else begin
                        rpt_next = rpt_reg + RPT_W'(1);
                    end
                end
            end
            ARM_RELEASE: begin
                if (!s2 && ctr_at_last) begin
                    rpt_next = '0;
                end
            end
            default: begin
                rpt_next = '0;
            end
        endcase
    end
`endif

    // Output logic: the level follows accepted transitions, and each pulse is
    // asserted for the single cycle after its acceptance edge.
    always_comb begin
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state_reg)
            ARM_PRESS: begin
                if (s2 && ctr_at_last) begin
                    level_next = 1'b1;
                    press_next = 1'b1;
                end
            end
            ARM_RELEASE: begin
                if (!s2 && ctr_at_last) begin
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end
            end
            default: begin
                level_next = level_reg;
            end
        endcase
`ifdef BTN_REPEAT_EN
        if (rpt_fire) begin
            press_next = 1'b1;
        end
`endif
    end

    assign btn_level     = level_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Testbench for button_debounce_pulse, using DEBOUNCE_CYCLES=4,
// REPEAT_DELAY_CYCLES=20 and REPEAT_PERIOD_CYCLES=8. Accept latency is
// 2 + 4 = 6 edges after the first edge that samples the new raw value.
module tb_button_debounce_pulse;

    localparam int DEB    = 4;
    localparam int RDELAY = 20;
    localparam int RPER   = 8;
    localparam int LAT    = 2 + DEB;

    typedef struct packed {
        logic raw;
        logic rst_n;
        logic lvl;
        logic prs;
        logic rel;
    } vec_t;

    logic clk;
    logic rst_n;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    int n_checks;
    int n_fail;
    int both_high;
    vec_t vecs[$];

    button_debounce_pulse #(
        .DEBOUNCE_CYCLES     (DEB),
        .CTR_W               (20),
        .REPEAT_DELAY_CYCLES (RDELAY),
        .REPEAT_PERIOD_CYCLES(RPER),
        .RPT_W               (26)
    ) dut (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (rst_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watch for both pulses being high in the same cycle.
    always @(negedge clk) begin
        if (press_pulse && release_pulse) both_high <= both_high + 1;
    end

    task automatic add_vec(input logic raw, input logic rn, input logic lvl,
                           input logic prs, input logic rel);
        vec_t v;
        v.raw = raw; v.rst_n = rn; v.lvl = lvl; v.prs = prs; v.rel = rel;
        vecs.push_back(v);
    endtask

    task automatic check_outs(input string name, input logic lvl, input logic prs,
                              input logic rel);
        n_checks++;
        if ({btn_level, press_pulse, release_pulse} !== {lvl, prs, rel}) begin
            n_fail++;
            $display("FAIL %s: level/press/release got %b%b%b expected %b%b%b",
                     name, btn_level, press_pulse, release_pulse, lvl, prs, rel);
        end else begin
            $display("ok   %s: level/press/release %b%b%b", name, btn_level,
                     press_pulse, release_pulse);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    initial begin
        int press_times[$];
        int rel_count;
        int exp_times[$];
        logic [7:0] bounce;

        n_checks  = 0;
        n_fail    = 0;
        both_high = 0;
        bounce    = 8'b00110011; // bit k = raw for bounce step k (1,1,0,0,1,1,0,0)

        // ---------------- vector table ----------------
        // Idle after reset.
        for (int k = 0; k < 2; k++) add_vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Clean press, held.
        for (int k = 0; k < 12; k++) add_vec(1'b1, 1'b1, k >= LAT, k == LAT, 1'b0);
        // Clean release.
        for (int k = 0; k < 10; k++) add_vec(1'b0, 1'b1, k < LAT, 1'b0, k == LAT);
        // Glitch of 3 cycles, then a glitch of exactly DEB cycles: both rejected.
        for (int k = 0; k < 3; k++)  add_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)  add_vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)  add_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)  add_vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Shortest accepted press (DEB+1 cycles), followed by its release.
        for (int k = 0; k < 15; k++)
            add_vec(k < 5, 1'b1, (k >= LAT) && (k < 5 + LAT), k == LAT, k == 5 + LAT);
        // Bouncing press: one pulse, timed from the last rising sample (k=8).
        for (int k = 0; k < 20; k++)
            add_vec((k >= 8) ? 1'b1 : bounce[k], 1'b1, k >= 8 + LAT, k == 8 + LAT, 1'b0);
        // Release bounce of 2 cycles: stays HELD, no pulse.
        for (int k = 0; k < 8; k++) add_vec(k >= 2, 1'b1, 1'b1, 1'b0, 1'b0);
        // Real release.
        for (int k = 0; k < 10; k++) add_vec(1'b0, 1'b1, k < LAT, 1'b0, k == LAT);
        // Reset in ARM_PRESS at ctr=2, then re-qualification after deassertion.
        for (int k = 0; k < 5; k++) add_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) add_vec(1'b1, 1'b1, k >= LAT, k == LAT, 1'b0);

        // ---------------- reset state ----------------
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset_state", 1'b0, 1'b0, 1'b0);

        // ---------------- table-driven run ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            btn_raw = vecs[i].raw;
            rst_n   = vecs[i].rst_n;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec[%0d] raw=%b rst_n=%b", i, vecs[i].raw, vecs[i].rst_n),
                       vecs[i].lvl, vecs[i].prs, vecs[i].rel);
        end

        // ---------------- reset while HELD: immediate clear ----------------
        rst_n = 1'b0;
        #1;
        check_outs("rst_async_held", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outs("rst_held_cycle", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        press_times.delete();
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (press_pulse) press_times.push_back(k);
        end
        check_int("rst_requal_press_count", press_times.size(), 1);
        if (press_times.size() > 0)
            check_int("rst_requal_press_edge", press_times[0], LAT);

        // ---------------- auto-repeat / single pulse on long hold ----------------
        btn_raw = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check_outs("idle_before_hold", 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b1;
        press_times.delete();
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            #1;
            if (press_pulse) press_times.push_back(k);
        end
        exp_times.delete();
        exp_times.push_back(LAT);
`ifdef BTN_REPEAT_EN
        for (int t = LAT + RDELAY; t < 64; t += RPER) exp_times.push_back(t);
`endif
        check_int("hold_press_count", press_times.size(), exp_times.size());
        for (int j = 0; j < exp_times.size(); j++) begin
            check_int($sformatf("hold_press_edge[%0d]", j),
                      (j < press_times.size()) ? press_times[j] : -1, exp_times[j]);
        end
        check_outs("hold_level", 1'b1, 1'b0, 1'b0);

        btn_raw   = 1'b0;
        rel_count = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (release_pulse) rel_count++;
        end
        check_int("hold_release_count", rel_count, 1);
        check_outs("final_idle", 1'b0, 1'b0, 1'b0);
        check_int("press_release_overlap", both_high, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
